// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

  typedef enum logic [2:0] {
    PAT_NONE    = 3'd0,
    PAT_WAVE    = 3'd1,
    PAT_SYNC    = 3'd2,
    PAT_CLUSTER = 3'd3,
    PAT_BURST   = 3'd4,
    PAT_INHIB   = 3'd5,
    PAT_RSV6    = 3'd6,
    PAT_RSV7    = 3'd7
  } pattern_e;

  // Accumulator headroom above W: one sign bit plus room for
  // state + ext + cur (each up to 2^W-1) without wrapping before the clamp.
  localparam int ACC_GUARD = 3;

  // Ring index (i + off) mod n, correct for negative offsets.
  function automatic int ring_idx(input int i, input int off, input int n);
    return ((i + off) % n + n) % n;
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One LIF neuron: leaky integration with clamp, threshold/refractory handling
// and a saturating spike counter.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int THRESH     = 128,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         inhibit,
  input  logic [W-1:0] ext,
  input  logic [W-1:0] cur,
  output logic         spike,
  output logic [W-1:0] state,
  output logic [W-1:0] cnt
);

  localparam int AW = W + ACC_GUARD;
  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic signed [AW-1:0] MAXS = AW'((2 ** W) - 1);
  localparam logic [W-1:0] TH = W'(THRESH);

  logic [RW-1:0] refr;
  logic signed [AW-1:0] st_x, lk_x, ext_x, cur_x, acc;
  logic [W-1:0] s_clamp;
  logic fire;

  // Integrate one step at widened signed precision, then clamp to [0, 2^W-1].
  always_comb begin
    st_x = AW'(state);
    lk_x = AW'(state >> LEAK_SHIFT);
    ext_x = AW'(ext);
    cur_x = AW'(cur);
    acc = inhibit ? (st_x - lk_x + ext_x - cur_x) : (st_x - lk_x + ext_x + cur_x);
    if (acc[AW-1]) s_clamp = '0;
    else if (acc > MAXS) s_clamp = '1;
    else s_clamp = acc[W-1:0];
    fire = (refr == '0) && (s_clamp >= TH);
  end

  // Membrane, refractory and spike registers advance only on step cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      refr  <= '0;
      spike <= 1'b0;
    end else if (en) begin
      if (refr != '0) begin
        state <= '0;
        refr  <= refr - RW'(1);
        spike <= 1'b0;
      end else if (fire) begin
        state <= '0;
        refr  <= RW'(REFRAC);
        spike <= 1'b1;
      end else begin
        state <= s_clamp;
        spike <= 1'b0;
      end
    end
  end

  // Saturating spike counter; clear wins over a same-cycle spike.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && fire && (cnt != '1)) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/lif_array.sv
// Array of N LIF neurons with registered inputs, selectable coupling topology
// and a registered spike-count readout.
module lif_array
  import lif_pkg::*;
#(
  parameter int N          = 8,
  parameter int W          = 8,
  parameter int THRESH     = 128,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           pattern,
  input  logic [W-1:0]         base_current,
  input  logic [W-1:0]         coupling,
  input  logic                 clr_counts,
  input  logic [$clog2(N)-1:0] cnt_sel,
  output logic [N-1:0]         spikes,
  output logic [W-1:0]         state0,
  output logic [W-1:0]         cnt_out
);

  pattern_e pattern_r;
  logic [W-1:0] base_r, coupling_r;
  logic [N-1:0][W-1:0] state_all, cnt_all;
  logic inhibit;

  assign inhibit = (pattern_r == PAT_INHIB);
  assign state0  = state_all[0];

  // Input stage: captured every cycle regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r  <= PAT_NONE;
      base_r     <= '0;
      coupling_r <= '0;
    end else begin
      pattern_r  <= pattern_e'(pattern);
      base_r     <= base_current;
      coupling_r <= coupling;
    end
  end

  for (genvar g = 0; g < N; g++) begin : gen_n
    localparam int PREV = ring_idx(g, -1, N);
    localparam int NEXT = ring_idx(g, 1, N);
    localparam int OPP  = ring_idx(g, N / 2, N);
    localparam logic [W:0] IDX = (W + 1)'(g);

    logic [W:0]   ext_sum;
    logic [W-1:0] ext_sat;
    logic [W-1:0] cur_q;

    assign ext_sum = {1'b0, base_r} + IDX;
    assign ext_sat = ext_sum[W] ? '1 : ext_sum[W-1:0];

    // Coupling current for the next step, derived from last step's spikes.
    always_ff @(posedge clk) begin
      if (rst) cur_q <= '0;
      else if (en) begin
        case (pattern_r)
          PAT_WAVE, PAT_INHIB: cur_q <= spikes[PREV] ? coupling_r : '0;
          PAT_SYNC:            cur_q <= (|spikes) ? coupling_r : '0;
          PAT_CLUSTER:         cur_q <= spikes[OPP] ? coupling_r : '0;
          PAT_BURST:           cur_q <= (spikes[PREV] | spikes[NEXT]) ? coupling_r : '0;
          default:             cur_q <= '0;
        endcase
      end
    end

    lif_neuron_core #(
      .W(W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) u_core (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .clr    (clr_counts),
      .inhibit(inhibit),
      .ext    (ext_sat),
      .cur    (cur_q),
      .spike  (spikes[g]),
      .state  (state_all[g]),
      .cnt    (cnt_all[g])
    );
  end

  // Registered counter readout; indices beyond N-1 read as zero.
  always_ff @(posedge clk) begin
    if (rst) cnt_out <= '0;
    else if (int'(cnt_sel) < N) cnt_out <= cnt_all[cnt_sel];
    else cnt_out <= '0;
  end

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: reference-model scoreboard every cycle,
// a table of known trajectory points and hand sequences for corner cases.
module tb_lif_array;

  localparam int N = 8, W = 8, TH = 128, LS = 4, RF = 2;
  localparam int MAXV = 255;

  logic clk, rst, en, clr_counts;
  logic [2:0] pattern;
  logic [W-1:0] base_current, coupling;
  logic [2:0] cnt_sel;
  logic [N-1:0] spikes;
  logic [W-1:0] state0, cnt_out;

  int total = 0;
  int bad = 0;

  lif_array #(.N(N), .W(W), .THRESH(TH), .LEAK_SHIFT(LS), .REFRAC(RF)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern),
    .base_current(base_current), .coupling(coupling),
    .clr_counts(clr_counts), .cnt_sel(cnt_sel),
    .spikes(spikes), .state0(state0), .cnt_out(cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural reference: integer arrays, one call per clock edge.
  int m_st[N], m_rf[N], m_sp[N], m_cur[N], m_cnt[N];
  int m_pat, m_base, m_coup, m_cnt_out;

  function automatic int model_spikes();
    int v = 0;
    for (int i = 0; i < N; i++) v |= (m_sp[i] << i);
    return v;
  endfunction

  task automatic model_edge();
    int nst[N], nrf[N], nsp[N], ncur[N];
    int any, ext, s, src;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = 0; m_rf[i] = 0; m_sp[i] = 0; m_cur[i] = 0; m_cnt[i] = 0;
      end
      m_pat = 0; m_base = 0; m_coup = 0; m_cnt_out = 0;
      return;
    end
    m_cnt_out = (int'(cnt_sel) < N) ? m_cnt[cnt_sel] : 0;
    for (int i = 0; i < N; i++) begin
      nst[i] = m_st[i]; nrf[i] = m_rf[i]; nsp[i] = m_sp[i]; ncur[i] = m_cur[i];
    end
    if (en) begin
      any = 0;
      for (int i = 0; i < N; i++) any |= m_sp[i];
      for (int i = 0; i < N; i++) begin
        ext = m_base + i;
        if (ext > MAXV) ext = MAXV;
        if (m_rf[i] > 0) begin
          nst[i] = 0; nrf[i] = m_rf[i] - 1; nsp[i] = 0;
        end else begin
          s = m_st[i] - (m_st[i] >> LS) + ext + ((m_pat == 5) ? -m_cur[i] : m_cur[i]);
          if (s < 0) s = 0;
          if (s > MAXV) s = MAXV;
          if (s >= TH) begin nsp[i] = 1; nst[i] = 0; nrf[i] = RF; end
          else begin nsp[i] = 0; nst[i] = s; nrf[i] = 0; end
        end
        case (m_pat)
          1, 5: src = m_sp[(i + N - 1) % N];
          2:    src = any;
          3:    src = m_sp[(i + N / 2) % N];
          4:    src = m_sp[(i + N - 1) % N] | m_sp[(i + 1) % N];
          default: src = 0;
        endcase
        ncur[i] = src ? m_coup : 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (clr_counts) m_cnt[i] = 0;
      else if (en && nsp[i] == 1 && m_cnt[i] < MAXV) m_cnt[i] = m_cnt[i] + 1;
      m_st[i] = nst[i]; m_rf[i] = nrf[i]; m_sp[i] = nsp[i]; m_cur[i] = ncur[i];
    end
    m_pat = int'(pattern); m_base = int'(base_current); m_coup = int'(coupling);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model_spikes", 32'(spikes), 32'(model_spikes()));
    check("model_state0", 32'(state0), 32'(m_st[0]));
    check("model_cnt_out", 32'(cnt_out), 32'(m_cnt_out));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr_counts = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Known trajectory of neuron 0 with pattern 0, base 16.
  typedef struct { int step; int st0; int sp0; int cnt; } vec_t;
  vec_t tbl[17];

  task automatic check_step(input int s);
    for (int r = 0; r < 17; r++) begin
      if (tbl[r].step == s) begin
        check("tbl_state0", 32'(state0), 32'(tbl[r].st0));
        check("tbl_spike0", 32'(spikes[0]), 32'(tbl[r].sp0));
        check("tbl_cnt_out", 32'(cnt_out), 32'(tbl[r].cnt));
      end
    end
  endtask

  initial begin
    int exp_sp;
    tbl = '{
      '{1, 16, 0, 0},  '{2, 31, 0, 0},  '{3, 46, 0, 0},  '{4, 60, 0, 0},
      '{5, 73, 0, 0},  '{6, 85, 0, 0},  '{7, 96, 0, 0},  '{8, 106, 0, 0},
      '{9, 116, 0, 0}, '{10, 125, 0, 0}, '{11, 0, 1, 0}, '{12, 0, 0, 1},
      '{13, 0, 0, 1},  '{14, 16, 0, 1},  '{15, 31, 0, 1}, '{24, 0, 1, 1},
      '{25, 0, 0, 2}
    };
    rst = 1'b1; en = 1'b0; clr_counts = 1'b0; pattern = 3'd0;
    base_current = '0; coupling = '0; cnt_sel = '0;

    // Reset state
    do_reset();
    check("reset_spikes", 32'(spikes), 32'd0);
    check("reset_state0", 32'(state0), 32'd0);
    check("reset_cnt_out", 32'(cnt_out), 32'd0);

    // Isolated neuron trajectory, period 13
    pattern = 3'd0; base_current = 8'd16; coupling = 8'd0; cnt_sel = 3'd0;
    tick();
    en = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      tick();
      check_step(s);
    end

    // Sync saturation with a mid-run counter clear on a spike step
    do_reset();
    pattern = 3'd2; base_current = 8'd255; coupling = 8'd255; cnt_sel = 3'd3;
    tick();
    en = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      clr_counts = (s == 7);
      tick();
      exp_sp = ((s - 1) % 3 == 0) ? 8'hFF : 0;
      check("sync_spikes", 32'(spikes), 32'(exp_sp));
      if (s == 7) check("sync_cnt_before_clr", 32'(cnt_out), 32'd2);
      if (s == 8 || s == 9) check("sync_cnt_after_clr", 32'(cnt_out), 32'd0);
    end
    clr_counts = 1'b0;

    // Wave: a lone spike on neuron 7 travels around the ring, 2 steps per hop
    do_reset();
    pattern = 3'd1; base_current = 8'd121; coupling = 8'd200; cnt_sel = 3'd0;
    tick();
    base_current = 8'd0;
    en = 1'b1;
    for (int s = 1; s <= 18; s++) begin
      tick();
      if (s == 1) exp_sp = 8'h80;
      else if (s % 2 == 1) exp_sp = 1 << ((s - 3) / 2);
      else exp_sp = 0;
      check("wave_spikes", 32'(spikes), 32'(exp_sp));
    end

    // Inhibitory wave: neuron 0 clamped to 0 after its predecessor fires
    do_reset();
    pattern = 3'd5; base_current = 8'd16; coupling = 8'd255; cnt_sel = 3'd0;
    tick();
    en = 1'b1;
    for (int s = 1; s <= 11; s++) begin
      tick();
      if (s == 8)  check("inhib_state0_pre", 32'(state0), 32'd106);
      if (s == 9)  check("inhib_state0_clamp", 32'(state0), 32'd0);
      if (s == 10) check("inhib_state0_restart", 32'(state0), 32'd16);
      if (s == 11) check("inhib_spike0_delayed", 32'(spikes[0]), 32'd0);
    end

    // Freeze with en=0, then resume on the same trajectory
    do_reset();
    pattern = 3'd0; base_current = 8'd16; coupling = 8'd0; cnt_sel = 3'd0;
    tick();
    en = 1'b1;
    for (int s = 1; s <= 5; s++) tick();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("freeze_state0", 32'(state0), 32'd73);
      check("freeze_spike0", 32'(spikes[0]), 32'd0);
    end
    en = 1'b1;
    for (int s = 6; s <= 12; s++) begin
      tick();
      check_step(s);
    end

    // Reset inside the refractory window
    do_reset();
    tick();
    en = 1'b1;
    for (int s = 1; s <= 11; s++) tick();
    check("pre_reset_spike0", 32'(spikes[0]), 32'd1);
    rst = 1'b1; clr_counts = 1'b0;
    tick();
    check("midreset_spikes", 32'(spikes), 32'd0);
    check("midreset_state0", 32'(state0), 32'd0);
    check("midreset_cnt_out", 32'(cnt_out), 32'd0);
    rst = 1'b0; en = 1'b0;
    tick();
    en = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      check_step(s);
    end

    // Randomized run against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        pattern = 3'($urandom_range(0, 7));
        base_current = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
        coupling = 8'($urandom_range(0, 255));
      end
      en = ($urandom_range(0, 9) != 0);
      clr_counts = ($urandom_range(0, 49) == 0);
      cnt_sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; clr_counts = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
